// File: rtl/mem_arb_pkg.sv
// Shared encodings and default timing constants for the IF/DM memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_owner_t;

    localparam int MEM_LAT_DEF    = 4;
    localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag; times how long memory controls are held.
import mem_arb_pkg::*;

module mem_arb_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one multi-cycle memory port (DM has priority).
// Optional IF anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = MEM_LAT_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic [DATA_W-1:0] if_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rdy,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    gnt_owner_t        gnt_q, gnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              lat_load, lat_dec, lat_zero;
    logic [3:0]        lat_cnt;
    logic              force_if;
    logic              pick_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_if = (starve_cnt_q == STARVE_W'(STARVE_MAX));

    // Counts consecutive DM grants that bypassed a waiting fetch; any IF grant or idle fetch side resets it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (pick_dm) begin
                if (!force_if) starve_cnt_d = starve_cnt_q + 1'b1;
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end
`else
    assign force_if = 1'b0;
`endif

    assign pick_dm = dm_req && !(if_req && force_if);

    mem_arb_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lat_load),
        .load_val_i (LAT_INIT),
        .dec_i      (lat_dec),
        .cnt_o      (lat_cnt),
        .zero_o     (lat_zero)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    gnt_d       = pick_dm ? GNT_DM : GNT_IF;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_dm && dm_we;
                    mem_addr_d  = pick_dm ? dm_addr : if_addr;
                    mem_wdata_d = pick_dm ? dm_wdata : '0;
                    lat_load    = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_zero) begin
                    if (gnt_q == GNT_IF)  if_data_d  = mem_rdata;
                    else if (!mem_we_q)   dm_rdata_d = mem_rdata;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_rdy    = (state_q == DONE) && (gnt_q == GNT_IF);
    assign dm_rdy    = (state_q == DONE) && (gnt_q == GNT_DM);
    assign if_data   = if_data_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req && !if_rdy) || (dm_req && !dm_rdy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;

    localparam int LAT  = 4;
    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic        if_rdy, dm_rdy, mem_en, mem_we, stall;
    logic [15:0] if_data, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] pmem [0:255];
    logic [15:0] mmem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)
`ifdef MEM_ARB_STARVE_GUARD_EN
        , .STARVE_MAX(SMAX)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdy(dm_rdy), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    // Physical memory: reads are combinational, stores land on each enabled write edge.
    assign mem_rdata = pmem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) pmem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 'since' counts cycles since the latest grant; a transaction owns the port for LAT+1 cycles.
    int          since = 1000;
    logic        m_dm, m_we;
    logic [15:0] m_addr, m_wdata, e_if_data, e_dm_rdata;
    int          starve = 0;

    task automatic model_cycle();
        logic e_en, e_if_rdy, e_dm_rdy, g_if, g_dm;
        if (!rst_n) begin
            since = 1000; starve = 0; e_if_data = 16'h0; e_dm_rdata = 16'h0;
            m_dm = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
            return;
        end
        e_en     = (since >= 1) && (since <= LAT);
        e_if_rdy = (since == LAT + 1) && !m_dm;
        e_dm_rdy = (since == LAT + 1) && m_dm;
        chk("m_mem_en", 32'(mem_en), 32'(e_en));
        chk("m_mem_we", 32'(mem_we), 32'(e_en && m_we));
        chk("m_if_rdy", 32'(if_rdy), 32'(e_if_rdy));
        chk("m_dm_rdy", 32'(dm_rdy), 32'(e_dm_rdy));
        chk("m_if_data", 32'(if_data), 32'(e_if_data));
        chk("m_dm_rdata", 32'(dm_rdata), 32'(e_dm_rdata));
        chk("m_stall", 32'(stall), 32'((if_req && !e_if_rdy) || (dm_req && !e_dm_rdy)));
        if (e_en) chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
        if (e_en && m_we) chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        if (since == LAT) begin
            if (!m_dm)      e_if_data = mmem[m_addr[7:0]];
            else if (!m_we) e_dm_rdata = mmem[m_addr[7:0]];
            else            mmem[m_addr[7:0]] = m_wdata;
        end
        if ((since >= 1) && (since <= LAT + 1)) begin
            since++;
            return;
        end
        g_if = 1'b0; g_dm = 1'b0;
        if (dm_req && if_req) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (starve == SMAX) g_if = 1'b1; else g_dm = 1'b1;
`else
            g_dm = 1'b1;
`endif
        end else if (dm_req) g_dm = 1'b1;
        else if (if_req) g_if = 1'b1;
        if (!if_req) starve = 0;
        else if (g_dm) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else starve = 0;
        if (g_dm) begin
            m_dm = 1'b1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; since = 1;
        end else if (g_if) begin
            m_dm = 1'b0; m_we = 1'b0; m_addr = if_addr; m_wdata = 16'h0; since = 1;
        end else if (since < 1000) begin
            since++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_tests();
        int cnt, ifr, dmr;
        // 1: reset, including an abandoned fetch
        idle(3);
        rst_n = 1'b1;
        step();
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_if_data", 32'(if_data), 32'h0);
        chk("rst_dm_rdata", 32'(dm_rdata), 32'h0);
        if_req = 1'b1; if_addr = 16'h0010;
        idle(2);
        chk("rst_pre_en", 32'(mem_en), 32'h1);
        #2 rst_n = 1'b0; if_req = 1'b0;
        #1 chk("rst_async_en", 32'(mem_en), 32'h0);
        cnt = 0;
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt += int'(if_rdy) + int'(dm_rdy) + int'(mem_en);
        end
        chk("rst_no_rdy", 32'(cnt), 32'h0);
        // 2: single fetch
        if_req = 1'b1; if_addr = 16'h0010; cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 4) cnt += int'(mem_en);
            if (k == 4) chk("fetch_early_rdy", 32'(if_rdy), 32'h0);
            if (k == 5) begin
                chk("fetch_rdy", 32'(if_rdy), 32'h1);
                chk("fetch_data", 32'(if_data), 32'hA5A5);
                if_req = 1'b0;
            end
        end
        chk("fetch_en_cycles", 32'(cnt), 32'd4);
        idle(2);
        // 3: collision, DM first
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        #1 cnt = int'(stall);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 10) cnt += int'(stall);
            if (k == 5) begin
                chk("coll_dm_rdy", 32'(dm_rdy), 32'h1);
                chk("coll_if_wait", 32'(if_rdy), 32'h0);
                chk("coll_dm_data", 32'(dm_rdata), 32'hBEEF);
                dm_req = 1'b0;
            end
            if (k == 7) chk("coll_if_addr", 32'(mem_addr), 32'h0020);
            if (k == 11) begin
                chk("coll_if_rdy", 32'(if_rdy), 32'h1);
                chk("coll_if_data", 32'(if_data), 32'hC020);
                if_req = 1'b0;
            end
        end
        chk("coll_stall_cycles", 32'(cnt), 32'd11);
        idle(2);
        // 4: store with address changed after grant
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234; cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin dm_addr = 16'hFFFF; dm_wdata = 16'h0000; end
            if (k <= 4) cnt += int'(mem_we && (mem_addr == 16'h0300) && (mem_wdata == 16'h1234));
            if (k == 5) begin
                chk("store_rdy", 32'(dm_rdy), 32'h1);
                chk("store_rdata_kept", 32'(dm_rdata), 32'hBEEF);
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end
        chk("store_hold_cycles", 32'(cnt), 32'd4);
        chk("store_mem", 32'(pmem[8'h00]), 32'h1234);
        idle(2);
        // 5: persistent DM traffic against a waiting fetch
        if_req = 1'b1; if_addr = 16'h0030;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040;
        ifr = 0; dmr = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            ifr += int'(if_rdy);
            dmr += int'(dm_rdy);
        end
        if_req = 1'b0; dm_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_dm_grants", 32'(dmr), 32'd2);
        chk("starve_if_grants", 32'(ifr), 32'd1);
`else
        chk("starve_dm_grants", 32'(dmr), 32'd3);
        chk("starve_if_grants", 32'(ifr), 32'd0);
`endif
        idle(3);
        // 6: back-to-back fetches
        if_req = 1'b1; if_addr = 16'h0010;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 5) begin
                chk("b2b_rdy1", 32'(if_rdy), 32'h1);
                if_addr = 16'h0011;
            end
            if (k == 6) chk("b2b_idle_en", 32'(mem_en), 32'h0);
            if (k == 7) chk("b2b_addr2", 32'(mem_addr), 32'h0011);
            if (k == 11) begin
                chk("b2b_rdy2", 32'(if_rdy), 32'h1);
                chk("b2b_data2", 32'(if_data), 32'h5A5A);
                if_req = 1'b0;
            end
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            pmem[i] = {8'hC0, 8'(i)};
            mmem[i] = {8'hC0, 8'(i)};
        end
        pmem[8'h10] = 16'hA5A5; mmem[8'h10] = 16'hA5A5;
        pmem[8'h11] = 16'h5A5A; mmem[8'h11] = 16'h5A5A;
        pmem[8'h00] = 16'hBEEF; mmem[8'h00] = 16'hBEEF;
        rst_n = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    model_cycle();
                end
            end
            run_tests();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
